// File: rtl/cordic_request_arbiter_if.sv
// Request, response and engine channels of the CORDIC request arbiter.
// slave is the arbiter side; master is the requester/engine environment side.
interface cordic_request_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int ITER_W  = 6
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_x;
    logic [NUM_REQ*DATA_W-1:0] req_y;
    logic [NUM_REQ*ITER_W-1:0] req_iters;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_x;
    logic [DATA_W-1:0]         rsp_y;
    logic [DATA_W-1:0]         rsp_angle;
    logic                      rsp_err;

    logic                      eng_start;
    logic [DATA_W-1:0]         eng_x;
    logic [DATA_W-1:0]         eng_y;
    logic [ITER_W-1:0]         eng_iters;
    logic                      eng_done;
    logic [DATA_W-1:0]         eng_x_final;
    logic [DATA_W-1:0]         eng_y_final;
    logic [DATA_W-1:0]         eng_angle;

    modport slave (
        input  req_valid, req_x, req_y, req_iters, rsp_ready,
        input  eng_done, eng_x_final, eng_y_final, eng_angle,
        output req_ready, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_angle, rsp_err,
        output eng_start, eng_x, eng_y, eng_iters
    );

    modport master (
        output req_valid, req_x, req_y, req_iters, rsp_ready,
        output eng_done, eng_x_final, eng_y_final, eng_angle,
        input  req_ready, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_angle, rsp_err,
        input  eng_start, eng_x, eng_y, eng_iters
    );
endinterface

// File: rtl/cordic_request_arbiter.sv
// Round-robin arbiter sharing one iterative CORDIC vectoring engine between NUM_REQ requesters.
// Define CORDIC_ARB_TIMEOUT_EN to add a TIMEOUT_CYC watchdog on the wait for eng_done.
module cordic_request_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 64,
    parameter int ITER_W      = 6,
    parameter int TIMEOUT_CYC = 80
) (
    input  logic                   clk,
    input  logic                   reset_n,
    cordic_request_arbiter_if.slave bus,
    output logic                   busy
);
    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W:0]     scan_idx;
    logic [ID_W-1:0]   grant_id;
    logic              grant_any;
    logic [DATA_W-1:0] sel_x;
    logic [DATA_W-1:0] sel_y;
    logic [ITER_W-1:0] sel_iters;
    logic [ITER_W-1:0] iters_eff;

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ rather than 2^ID_W.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NUM_REQ))
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            if (!grant_any && bus.req_valid[scan_idx[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_iters = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                sel_x     = bus.req_x[k*DATA_W +: DATA_W];
                sel_y     = bus.req_y[k*DATA_W +: DATA_W];
                sel_iters = bus.req_iters[k*ITER_W +: ITER_W];
            end
        end
    end

    // A zero iteration count means "use the full 16-entry atan table".
    assign iters_eff = (sel_iters == '0) ? ITER_W'(16) : sel_iters;

    // Ready is gated by reset so no handshake can complete while the block is held in reset.
    always_comb begin
        bus.req_ready = '0;
        if (reset_n && state == IDLE && grant_any)
            bus.req_ready[grant_id] = 1'b1;
    end

    assign busy = (state != IDLE);

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            bus.eng_start <= 1'b0;
            bus.eng_x     <= '0;
            bus.eng_y     <= '0;
            bus.eng_iters <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_x     <= '0;
            bus.rsp_y     <= '0;
            bus.rsp_angle <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            bus.rsp_err   <= 1'b0;
            wait_cnt      <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        bus.eng_x     <= sel_x;
                        bus.eng_y     <= sel_y;
                        bus.eng_iters <= iters_eff;
                        bus.rsp_id    <= grant_id;
                        bus.eng_start <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.eng_start <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
                    wait_cnt      <= '0;
`endif
                    state         <= WAIT;
                end
                WAIT: begin
                    if (bus.eng_done) begin
                        bus.rsp_x     <= bus.eng_x_final;
                        bus.rsp_y     <= bus.eng_y_final;
                        bus.rsp_angle <= bus.eng_angle;
`ifdef CORDIC_ARB_TIMEOUT_EN
                        bus.rsp_err   <= 1'b0;
`endif
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
`ifdef CORDIC_ARB_TIMEOUT_EN
                    // Watchdog fires on the TIMEOUT_CYC-th wait cycle; a later eng_done lands outside WAIT.
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        bus.rsp_x     <= '0;
                        bus.rsp_y     <= '0;
                        bus.rsp_angle <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        rr_ptr        <= (bus.rsp_id == ID_W'(NUM_REQ - 1)) ? '0
                                                                            : bus.rsp_id + ID_W'(1);
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_request_arbiter.sv
// Scoreboard bench for cordic_request_arbiter: one tick() process drives requesters,
// models the engine and checks responses; tests run in sequence from one initial block.
module tb_cordic_request_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 64;
    localparam int ITER_W      = 6;
    localparam int TIMEOUT_CYC = 80;

    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [ITER_W-1:0] iters;
    } op_t;

    typedef struct packed {
        logic [1:0]        id;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] a;
        logic              err;
    } rsp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic busy;

    cordic_request_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ITER_W(ITER_W)) bus ();

    cordic_request_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ITER_W(ITER_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    rsp_t sb[$];
    op_t  req_q[NUM_REQ][$];

    // Engine model state and bookkeeping.
    logic              model_done;
    logic              force_done;
    logic [DATA_W-1:0] model_x, model_y, model_a;
    logic [DATA_W-1:0] cur_x, cur_y, last_x, last_y;
    logic [ITER_W-1:0] cur_it, last_iters;
    logic [NUM_REQ-1:0] acc;
    bit   pending, eng_respond, rsp_valid_q;
    int   lat_cnt, eng_lat, cyc, start_cnt, start_cyc, acc_cyc, rise_cyc, rsp_cnt;

    assign bus.eng_done    = model_done | force_done;
    assign bus.eng_x_final = force_done ? 64'h0BAD_0000_0000_0001 : model_x;
    assign bus.eng_y_final = force_done ? 64'h0BAD_0000_0000_0002 : model_y;
    assign bus.eng_angle   = force_done ? 64'h0BAD_0000_0000_0003 : model_a;

    function automatic rsp_t model(input int id, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                   input logic [ITER_W-1:0] it);
        rsp_t r;
        r.id  = 2'(id);
        r.x   = x + (y >> 1) + 64'(it);
        r.y   = y ^ {x[31:0], x[63:32]};
        r.a   = (x - y) ^ {58'd0, it};
        r.err = 1'b0;
        return r;
    endfunction

    function automatic op_t mk_op(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                  input logic [ITER_W-1:0] it);
        op_t o;
        o.x = x;
        o.y = y;
        o.iters = it;
        return o;
    endfunction

    function automatic logic [335:0] outs();
        return {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_x, bus.rsp_y, bus.rsp_angle,
                bus.rsp_err, bus.eng_start, bus.eng_x, bus.eng_y, bus.eng_iters, busy};
    endfunction

    task automatic send(input int id, input op_t op);
        req_q[id].push_back(op);
    endtask

    task automatic expect_rsp(input int id, input op_t op);
        sb.push_back(model(id, op.x, op.y, (op.iters == '0) ? ITER_W'(16) : op.iters));
    endtask

    // One clock: sample at negedge (scoreboard + engine model), drive requesters at posedge+1.
    task automatic tick();
        rsp_t got, exp, r;
        @(negedge clk);
        acc = bus.req_valid & bus.req_ready;
        if (acc != '0) acc_cyc = cyc;
        if (bus.rsp_valid && !rsp_valid_q) rise_cyc = cyc;
        rsp_valid_q = bus.rsp_valid;
        if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
            got = {bus.rsp_id, bus.rsp_x, bus.rsp_y, bus.rsp_angle, bus.rsp_err};
            total++;
            rsp_cnt++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got %h, required no response", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL rsp_data: got %h required %h", got, exp);
                end
            end
        end
        model_done = 1'b0;
        if (!reset_n) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                if (lat_cnt == 0) begin
                    r = model(0, cur_x, cur_y, cur_it);
                    model_x = r.x;
                    model_y = r.y;
                    model_a = r.a;
                    model_done = 1'b1;
                    pending = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end
            if (bus.eng_start) begin
                start_cnt++;
                start_cyc  = cyc;
                last_x     = bus.eng_x;
                last_y     = bus.eng_y;
                last_iters = bus.eng_iters;
                if (eng_respond) begin
                    pending = 1'b1;
                    lat_cnt = eng_lat;
                    cur_x   = bus.eng_x;
                    cur_y   = bus.eng_y;
                    cur_it  = bus.eng_iters;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
            if (req_q[i].size() > 0) begin
                bus.req_valid[i] = 1'b1;
                bus.req_x[i*DATA_W +: DATA_W]     = req_q[i][0].x;
                bus.req_y[i*DATA_W +: DATA_W]     = req_q[i][0].y;
                bus.req_iters[i*ITER_W +: ITER_W] = req_q[i][0].iters;
            end else begin
                bus.req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_rsp(input int target, input int budget, output bit ok);
        int n = 0;
        while (rsp_cnt < target && n < budget) begin
            tick();
            n++;
        end
        ok = (rsp_cnt >= target);
    endtask

    task automatic wait_start(input int target, input int budget, output bit ok);
        int n = 0;
        while (start_cnt < target && n < budget) begin
            tick();
            n++;
        end
        ok = (start_cnt >= target);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        total++;
        if (outs() !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0", outs());
        end
        reset_n = 1'b1;
        tick();
        total++;
        if ({busy, bus.rsp_valid, bus.req_ready} !== 6'b0) begin
            bad++;
            $display("FAIL reset_idle: got %b required 000000", {busy, bus.rsp_valid, bus.req_ready});
        end
    endtask

    task automatic test_fairness();
        op_t o[4];
        bit ok;
        eng_lat = 3;
        for (int i = 0; i < 4; i++) begin
            o[i] = mk_op(64'h10 * (i + 1), 64'h3_0000_0000 + 64'(i), ITER_W'(10 + i));
            send(i, o[i]);
        end
        for (int i = 0; i < 4; i++) expect_rsp(i, o[i]);
        wait_rsp(rsp_cnt + 4, 200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL fair_all4: got %0d responses, required 4", rsp_cnt); end
        send(1, o[1]);
        send(3, o[3]);
        expect_rsp(1, o[1]);
        expect_rsp(3, o[3]);
        wait_rsp(rsp_cnt + 2, 100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL fair_1_3: timeout, responses=%0d", rsp_cnt); end
        // rr_ptr must be back at 0 after serving id 3, so req0 beats req2.
        send(2, o[2]);
        send(0, o[0]);
        expect_rsp(0, o[0]);
        expect_rsp(2, o[2]);
        wait_rsp(rsp_cnt + 2, 100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL fair_wrap: timeout, responses=%0d", rsp_cnt); end
    endtask

    task automatic test_single_op();
        op_t o;
        int s0;
        bit ok;
        eng_lat = 7;
        s0 = start_cnt;
        o = mk_op(64'h1_0000_0000, 64'h1_0000_0000, ITER_W'(16));
        send(0, o);
        expect_rsp(0, o);
        wait_rsp(rsp_cnt + 1, 100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_timeout: responses=%0d", rsp_cnt); end
        total++;
        if (start_cnt - s0 !== 1) begin
            bad++;
            $display("FAIL single_start_pulses: got %0d required 1", start_cnt - s0);
        end
        total++;
        if ({last_x, last_y, last_iters} !== {o.x, o.y, o.iters}) begin
            bad++;
            $display("FAIL single_eng_ops: got %h %h %0d required %h %h %0d",
                     last_x, last_y, last_iters, o.x, o.y, o.iters);
        end
        total++;
        if (start_cyc - acc_cyc !== 1) begin
            bad++;
            $display("FAIL single_issue_latency: got %0d required 1", start_cyc - acc_cyc);
        end
    endtask

    task automatic test_back_pressure();
        op_t o0, o2;
        rsp_t snap;
        bit ok, stable, rdy_zero;
        int n;
        eng_lat = 2;
        bus.rsp_ready = 1'b0;
        o0 = mk_op(64'hFFFF_FFFF_8000_0000, 64'h0000_0002_4000_0000, ITER_W'(12));
        o2 = mk_op(64'h0000_0005_0000_0000, 64'hFFFF_FFFD_0000_0000, ITER_W'(20));
        send(0, o0);
        expect_rsp(0, o0);
        expect_rsp(2, o2);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 100) begin tick(); n++; end
        total++;
        if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_valid: got %b required 1", bus.rsp_valid); end
        send(2, o2);
        snap = {bus.rsp_id, bus.rsp_x, bus.rsp_y, bus.rsp_angle, bus.rsp_err};
        stable = 1'b1;
        rdy_zero = 1'b1;
        repeat (10) begin
            tick();
            if (bus.rsp_valid !== 1'b1 || {bus.rsp_id, bus.rsp_x, bus.rsp_y, bus.rsp_angle, bus.rsp_err} !== snap)
                stable = 1'b0;
            if (bus.req_ready !== '0) rdy_zero = 1'b0;
        end
        total++;
        if (!stable) begin bad++; $display("FAIL bp_stable: rsp %h changed from %h", bus.rsp_x, snap.x); end
        total++;
        if (!rdy_zero) begin bad++; $display("FAIL bp_req_ready: got nonzero required 0"); end
        bus.rsp_ready = 1'b1;
        tick();
        total++;
        if (bus.req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL bp_reaccept: got %b required 0100", bus.req_ready);
        end
        wait_rsp(rsp_cnt + 1, 100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_req2_done: timeout, responses=%0d", rsp_cnt); end
    endtask

    task automatic test_iters();
        op_t o;
        bit ok;
        eng_lat = 0;
        o = mk_op(64'h0000_0003_0000_0000, 64'h0000_0004_0000_0000, ITER_W'(0));
        send(1, o);
        expect_rsp(1, o);
        wait_rsp(rsp_cnt + 1, 100, ok);
        total++;
        if (!ok || last_iters !== ITER_W'(16)) begin
            bad++;
            $display("FAIL iters_zero: got %0d required 16", last_iters);
        end
        o.iters = ITER_W'(5);
        send(1, o);
        expect_rsp(1, o);
        wait_rsp(rsp_cnt + 1, 100, ok);
        total++;
        if (!ok || last_iters !== ITER_W'(5)) begin
            bad++;
            $display("FAIL iters_five: got %0d required 5", last_iters);
        end
    endtask

    task automatic test_timeout();
        op_t o;
        bit ok;
        o = mk_op(64'h0000_0007_0000_0000, 64'h0000_0001_0000_0000, ITER_W'(9));
        eng_respond = 1'b0;
        send(3, o);
        wait_start(start_cnt + 1, 100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL to_start: no eng_start seen"); end
`ifdef CORDIC_ARB_TIMEOUT_EN
        begin
            rsp_t e;
            int r0;
            e = '0;
            e.id  = 2'd3;
            e.err = 1'b1;
            sb.push_back(e);
            wait_rsp(rsp_cnt + 1, 200, ok);
            total++;
            if (!ok || rise_cyc - start_cyc !== TIMEOUT_CYC + 1) begin
                bad++;
                $display("FAIL to_latency: got %0d required %0d", rise_cyc - start_cyc, TIMEOUT_CYC + 1);
            end
            r0 = rsp_cnt;
            force_done = 1'b1;
            tick();
            force_done = 1'b0;
            repeat (4) tick();
            total++;
            if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || rsp_cnt != r0) begin
                bad++;
                $display("FAIL to_late_done: busy=%b rsp_valid=%b required 0 0", busy, bus.rsp_valid);
            end
            eng_respond = 1'b1;
        end
`else
        begin
            bit stuck = 1'b1;
            repeat (100) begin
                tick();
                if (busy !== 1'b1 || bus.rsp_valid !== 1'b0) stuck = 1'b0;
            end
            total++;
            if (!stuck) begin
                bad++;
                $display("FAIL no_timeout_stuck: busy=%b rsp_valid=%b required 1 0", busy, bus.rsp_valid);
            end
        end
`endif
    endtask

    task automatic test_reset_mid_op();
        op_t o0, o3;
        bit ok;
        if (busy !== 1'b1) begin
            eng_respond = 1'b0;
            send(2, mk_op(64'h0000_0009_0000_0000, 64'h0000_0002_0000_0000, ITER_W'(7)));
            wait_start(start_cnt + 1, 100, ok);
        end
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        total++;
        if (outs() !== '0) begin
            bad++;
            $display("FAIL reset_mid_wait: got %h required 0", outs());
        end
        eng_respond = 1'b1;
        eng_lat = 4;
        o0 = mk_op(64'h0000_0002_0000_0000, 64'h0000_0001_8000_0000, ITER_W'(14));
        o3 = mk_op(64'h0000_0006_0000_0000, 64'h0000_0003_0000_0000, ITER_W'(11));
        send(3, o3);
        send(0, o0);
        expect_rsp(0, o0);
        expect_rsp(3, o3);
        repeat (2) tick();
        reset_n = 1'b1;
        wait_rsp(rsp_cnt + 2, 100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL reset_recover: timeout, responses=%0d", rsp_cnt); end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.req_valid = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.req_iters = '0;
        bus.rsp_ready = 1'b1;
        model_done = 1'b0;
        force_done = 1'b0;
        model_x = '0;
        model_y = '0;
        model_a = '0;
        pending = 1'b0;
        eng_respond = 1'b1;
        rsp_valid_q = 1'b0;
        eng_lat = 3;
        lat_cnt = 0;
        cyc = 0;
        start_cnt = 0;
        start_cyc = 0;
        acc_cyc = 0;
        rise_cyc = 0;
        rsp_cnt = 0;

        test_reset();
        test_fairness();
        test_single_op();
        test_back_pressure();
        test_iters();
        test_timeout();
        test_reset_mid_op();
        repeat (3) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drained: %0d responses outstanding, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
